// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter.
// Widths track the multiplier product and the five-digit display.
package bcd_pkg;
    localparam int BCD_DIGITS = 5;
    localparam int PROD_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Combinational, no latency; no flow control.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);
    assign dout = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, IN_W shifts per value.
// Latency IN_W+2 cycles accept-to-done; in_valid ignored while busy. Optional macro: BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = PROD_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en
);
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IN_W-1:0]     bin_sr;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] scratch_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    assign in_ready = !busy;

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_en;

    // A digit is lit when it or any more-significant digit is nonzero; digit 0 always lit.
    always_comb begin
        logic seen;
        blank_en = '0;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (scratch[4*i +: 4] != 4'd0);
            blank_en[i] = seen;
        end
        blank_en[0] = 1'b1;
    end
`else
    assign digit_en = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            cnt      <= '0;
            bin_sr   <= '0;
            scratch  <= '0;
`ifdef BIN2BCD_LZ_BLANK_EN
            digit_en <= '1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(IN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[4*DIGITS-2:0], bin_sr[IN_W-1]};
                    bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out  <= scratch;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
`ifdef BIN2BCD_LZ_BLANK_EN
                    digit_en <= blank_en;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
